board_scanner: RTL and testbench
================================

BOARD_SCANNER -- requirements
Module: board_scanner

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: start  input  1  one-cycle request to scan the board.
REQ-004 SHALL have port: flagged  input  64  per-tile flag bitmap; index = row*8+col.
REQ-005 SHALL have port: revealed  input  64  per-tile revealed bitmap.
REQ-006 SHALL have port: mines  input  64  per-tile mine bitmap.
REQ-007 SHALL have port: out_ready  input  1  downstream accepts the current tile.
REQ-008 SHALL have port: out_valid  output  1  out_index/out_code hold a valid tile.
REQ-009 SHALL have port: out_index  output  6  tile index being emitted.
REQ-010 SHALL have port: out_code  output  4  tile draw code.
REQ-011 SHALL have port: busy  output  1  high from snapshot until the scan completes.
REQ-012 SHALL have port: done  output  1  one-cycle pulse at scan end.
REQ-013 SHALL have port: revealed_count  output  7  count of revealed tiles (SCAN_STATS_EN only).
REQ-014 SHALL have port: flag_count  output  7  count of flagged tiles (SCAN_STATS_EN only).
REQ-015 SHALL have port: win  output  1  all non-mine tiles revealed and no mine revealed (SCAN_STATS_EN only).

Function
REQ-016 SHALL implement the FSM IDLE -> LOAD -> EMIT -> DONE -> IDLE.
REQ-017 SHALL move IDLE->LOAD on start=1; in LOAD, SHALL copy flagged, revealed and mines into internal snapshot registers and clear the tile counter to 0.
REQ-018 SHALL ignore start in all states other than IDLE.
REQ-019 SHALL, in EMIT, drive out_valid=1 with out_index equal to the counter; the first out_valid SHALL appear 2 cycles after the start cycle.
REQ-020 SHALL transfer a tile only on a cycle where out_valid and out_ready are both 1; on transfer, the counter SHALL increment.
REQ-021 SHALL hold out_index and out_code stable while out_valid=1 and out_ready=0.
REQ-022 SHALL emit tiles in order 0..63; after the tile-63 transfer, SHALL go to DONE, deassert out_valid, pulse done for exactly 1 cycle, then return to IDLE.
REQ-023 SHALL assert busy in LOAD, EMIT and DONE, and deassert it in IDLE.
REQ-024 SHALL compute out_code from the snapshot with this priority: flagged and not revealed = 10; not revealed = 9; revealed mine = 11; otherwise the count of mines among the 8 neighbours (0..8).
REQ-025 SHALL exclude off-board neighbours: row 0/7 and col 0/7 SHALL NOT wrap (corner max 3, edge max 5).
REQ-026 SHALL compute out_code combinationally from the snapshot and counter, with zero added latency versus out_index.
REQ-027 SHALL NOT let input bitmap changes after LOAD affect the current scan.

Reset
REQ-028 SHALL, on rst=0, immediately force the state to IDLE; out_valid, busy, done, out_index, out_code, the counter, the snapshots, revealed_count, flag_count and win SHALL all be 0.
REQ-029 SHALL abort any in-progress scan on reset, with no done pulse; after reset release, SHALL wait for a new start.

Configuration
REQ-030 SHALL, with macro SCAN_STATS_EN defined, accumulate revealed_count and flag_count over transferred tiles; at scan end, these SHALL hold the totals and win SHALL be updated in the DONE cycle; values SHALL hold until the next LOAD clears the accumulators.
REQ-031 SHALL, with SCAN_STATS_EN undefined, tie revealed_count, flag_count and win to constant 0 and omit the counter logic.

Verification
REQ-032 SHALL pass this check: all bitmaps 0, start, out_ready=1 -> 64 transfers of code 9, indices 0..63 in consecutive cycles, a done pulse on the next cycle, and busy low afterwards.
REQ-033 SHALL pass this check: mines = bits 1,8,9, revealed = all ones -> tile 0 code 3, tile 1 code 11, tile 63 code 0, and with stats win=0, revealed_count=64.
REQ-034 SHALL pass this check: out_ready toggled 0/1 each cycle -> each tile is held stable while ready=0, all 64 tiles are delivered once, and the scan takes 128 EMIT cycles.
REQ-035 SHALL pass this check: tile 5 flagged, not revealed, and tile 6 flagged and revealed -> code 10 and a code derived from tile 6's mines; flag_count=2.
REQ-036 SHALL pass this check: bitmaps changed mid-scan and start re-pulsed in EMIT -> the output matches the original snapshot and no restart occurs.
REQ-037 SHALL pass this check: rst asserted at tile 30 -> all outputs are 0 in the same cycle, and a new start after release rescans from index 0.

Source files
------------

// File: rtl/board_scanner.sv
// Scans a snapshot of an 8x8 minesweeper board and streams one draw code per tile over valid/ready.
// Optional SCAN_STATS_EN adds revealed/flag totals and a win flag for each scan.
module board_scanner (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] flagged,
  input  logic [63:0] revealed,
  input  logic [63:0] mines,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [5:0]  out_index,
  output logic [3:0]  out_code,
  output logic        busy,
  output logic        done,
  output logic [6:0]  revealed_count,
  output logic [6:0]  flag_count,
  output logic        win
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [5:0]  r_cnt;
  logic [63:0] r_fl, r_rv, r_mn;
  logic        w_xfer, w_last;
  logic [2:0]  w_row, w_col;
  logic [7:0]  w_nb;
  logic [3:0]  w_nbr, w_code;

  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;

  always_comb begin
    w_next    = r_state;
    out_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_LOAD;
      end
      S_LOAD: w_next = S_EMIT;
      S_EMIT: begin
        out_valid = 1'b1;
        if (out_ready && r_cnt == 6'd63) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_xfer = out_valid & out_ready;
  assign w_last = w_xfer & (r_cnt == 6'd63);

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_cnt <= '0;
      r_fl  <= '0;
      r_rv  <= '0;
      r_mn  <= '0;
    end else if (r_state == S_LOAD) begin
      r_cnt <= '0;
      r_fl  <= flagged;
      r_rv  <= revealed;
      r_mn  <= mines;
    end else if (w_xfer) begin
      r_cnt <= r_cnt + 6'd1;
    end

  // Neighbour taps use wrapping 6-bit index math; the row/col guards mask off-board taps.
  assign w_row = r_cnt[5:3];
  assign w_col = r_cnt[2:0];

  always_comb begin
    w_nb[0] = (w_row != 3'd0) && (w_col != 3'd0) && r_mn[r_cnt - 6'd9];
    w_nb[1] = (w_row != 3'd0)                    && r_mn[r_cnt - 6'd8];
    w_nb[2] = (w_row != 3'd0) && (w_col != 3'd7) && r_mn[r_cnt - 6'd7];
    w_nb[3] =                    (w_col != 3'd0) && r_mn[r_cnt - 6'd1];
    w_nb[4] =                    (w_col != 3'd7) && r_mn[r_cnt + 6'd1];
    w_nb[5] = (w_row != 3'd7) && (w_col != 3'd0) && r_mn[r_cnt + 6'd7];
    w_nb[6] = (w_row != 3'd7)                    && r_mn[r_cnt + 6'd8];
    w_nb[7] = (w_row != 3'd7) && (w_col != 3'd7) && r_mn[r_cnt + 6'd9];
  end

  always_comb begin
    w_nbr = '0;
    for (int k = 0; k < 8; k++) w_nbr = w_nbr + {3'b000, w_nb[k]};
  end

  always_comb begin
    if (r_fl[r_cnt] && !r_rv[r_cnt]) w_code = 4'd10;
    else if (!r_rv[r_cnt])           w_code = 4'd9;
    else if (r_mn[r_cnt])            w_code = 4'd11;
    else                             w_code = w_nbr;
  end

  // Gated so idle/reset outputs read zero rather than the code of tile 0.
  assign out_index = out_valid ? r_cnt  : 6'd0;
  assign out_code  = out_valid ? w_code : 4'd0;

`ifdef SCAN_STATS_EN
  logic [6:0] r_rev_cnt, r_flg_cnt;
  logic       r_win;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_rev_cnt <= '0;
      r_flg_cnt <= '0;
      r_win     <= 1'b0;
    end else if (r_state == S_LOAD) begin
      r_rev_cnt <= '0;
      r_flg_cnt <= '0;
      r_win     <= 1'b0;
    end else if (w_xfer) begin
      r_rev_cnt <= r_rev_cnt + {6'd0, r_rv[r_cnt]};
      r_flg_cnt <= r_flg_cnt + {6'd0, r_fl[r_cnt]};
      if (w_last) r_win <= (r_rv == ~r_mn);
    end

  assign revealed_count = r_rev_cnt;
  assign flag_count     = r_flg_cnt;
  assign win            = r_win;
`else
  assign revealed_count = 7'd0;
  assign flag_count     = 7'd0;
  assign win            = 1'b0;
`endif

endmodule

// File: tb/tb_board_scanner.sv
// Directed bench for board_scanner: scoreboard of per-tile codes plus timing, stall and reset checks.
module tb_board_scanner;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] flagged = '0, revealed = '0, mines = '0;
  logic        out_valid, busy, done, win;
  logic [5:0]  out_index;
  logic [3:0]  out_code;
  logic [6:0]  revealed_count, flag_count;

  board_scanner dut (
    .clk(clk), .rst(rst), .start(start), .flagged(flagged), .revealed(revealed),
    .mines(mines), .out_ready(out_ready), .out_valid(out_valid), .out_index(out_index),
    .out_code(out_code), .busy(busy), .done(done), .revealed_count(revealed_count),
    .flag_count(flag_count), .win(win)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; int code; } exp_t;
  exp_t q[$];
  int   n_assert = 0, n_fail = 0;
  int   emit_cyc, xfers;
  int   cap_code [64];
  logic       hold_v = 1'b0;
  logic [5:0] hold_idx;
  logic [3:0] hold_code;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_code(input logic [63:0] fl, rv, mn, input int i);
    int r, c, n;
    r = i / 8; c = i % 8; n = 0;
    if (fl[i] && !rv[i]) return 10;
    if (!rv[i]) return 9;
    if (mn[i]) return 11;
    for (int r2 = r - 1; r2 <= r + 1; r2++)
      for (int c2 = c - 1; c2 <= c + 1; c2++)
        if (r2 >= 0 && r2 < 8 && c2 >= 0 && c2 < 8 && !(r2 == r && c2 == c))
          n += int'(mn[r2*8 + c2]);
    return n;
  endfunction

  // Monitor: pops the scoreboard on every transfer and checks stall stability.
  always @(negedge clk) begin
    if (out_valid) begin
      exp_t e;
      emit_cyc++;
      if (hold_v) begin
        chk("hold_index", 64'(out_index), 64'(hold_idx));
        chk("hold_code", 64'(out_code), 64'(hold_code));
      end
      if (out_ready) begin
        if (q.size() == 0) begin
          n_fail++;
          $error("FAIL sb_underflow: got index %0d want no transfer", out_index);
        end else begin
          e = q.pop_front();
          chk("tile_index", 64'(out_index), 64'(e.idx));
          chk("tile_code", 64'(out_code), 64'(e.code));
          cap_code[out_index] = int'(out_code);
          xfers++;
        end
        hold_v = 1'b0;
      end else begin
        hold_v = 1'b1; hold_idx = out_index; hold_code = out_code;
      end
    end else hold_v = 1'b0;
  end

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 0);
    chk({tag, "_index"}, 64'(out_index), 0);
    chk({tag, "_code"}, 64'(out_code), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_revcnt"}, 64'(revealed_count), 0);
    chk({tag, "_flgcnt"}, 64'(flag_count), 0);
    chk({tag, "_win"}, 64'(win), 0);
  endtask

  // mode: 0 ready held high, 1 ready toggling, 2 mid-scan disturbance, 3 reset at tile 30
  task automatic run_scan(input logic [63:0] fl, rv, mn, input int mode);
    int cyc, done_cyc, first_v, e_rev, e_flg, e_win;
    bit stop;
    flagged = fl; revealed = rv; mines = mn;
    q.delete();
    for (int i = 0; i < 64; i++) q.push_back('{i, model_code(fl, rv, mn, i)});
    emit_cyc = 0; xfers = 0;
    @(posedge clk); #1;
    start = 1'b1; out_ready = (mode != 1);
    cyc = 0; done_cyc = -1; first_v = -1; stop = 0;
    while (done_cyc < 0 && cyc < 400 && !stop) begin
      @(posedge clk); #1;
      start = 1'b0; cyc++;
      if (mode == 1) out_ready = (cyc % 2 == 1);
      if (mode == 2 && cyc == 10) begin
        flagged = {$urandom, $urandom}; revealed = {$urandom, $urandom};
        mines = {$urandom, $urandom}; start = 1'b1;
      end
      if (mode == 3 && cyc == 32) begin
        rst = 1'b0; #1;
        chk_zero_outputs("rst_async");
        stop = 1;
      end else begin
        @(negedge clk);
        if (cyc == 1) chk("busy_in_load", 64'(busy), 1);
        if (out_valid && first_v < 0) first_v = cyc;
        if (done) done_cyc = cyc;
      end
    end
    if (mode == 3) begin
      chk("xfers_before_rst", 64'(xfers), 30);
      @(posedge clk); #1; rst = 1'b1; q.delete();
      repeat (4) begin
        @(negedge clk);
        chk("no_done_after_rst", 64'(done), 0);
        chk("idle_after_rst", 64'(busy), 0);
      end
      return;
    end
    chk("first_valid_cycle", 64'(first_v), 2);
    chk("done_cycle", 64'(done_cyc), (mode == 1) ? 130 : 66);
    chk("emit_cycles", 64'(emit_cyc), (mode == 1) ? 128 : 64);
    chk("xfer_total", 64'(xfers), 64);
    chk("sb_drained", 64'(q.size()), 0);
`ifdef SCAN_STATS_EN
    e_rev = $countones(rv); e_flg = $countones(fl); e_win = int'(rv == ~mn);
`else
    e_rev = 0; e_flg = 0; e_win = 0;
`endif
    chk("revealed_count", 64'(revealed_count), 64'(e_rev));
    chk("flag_count", 64'(flag_count), 64'(e_flg));
    chk("win", 64'(win), 64'(e_win));
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 0);
    chk("busy_after_done", 64'(busy), 0);
    chk("revealed_count_hold", 64'(revealed_count), 64'(e_rev));
    chk("win_hold", 64'(win), 64'(e_win));
  endtask

  initial begin
    logic [63:0] fl, rv, mn;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    rst = 1'b1;

    // Blank board: every tile hidden.
    run_scan('0, '0, '0, 0);
    chk("blank_tile0", 64'(cap_code[0]), 9);
    chk("blank_tile63", 64'(cap_code[63]), 9);

    // Mines at 1, 8, 9, everything revealed.
    mn = 64'h0000_0000_0000_0302;
    run_scan('0, '1, mn, 0);
    chk("m_tile0", 64'(cap_code[0]), 3);
    chk("m_tile1", 64'(cap_code[1]), 11);
    chk("m_tile63", 64'(cap_code[63]), 0);

    // Only a corner and an edge tile safe: saturated counts and a winning board.
    rv = 64'h9;
    run_scan('0, rv, ~rv, 0);
    chk("corner_max", 64'(cap_code[0]), 3);
    chk("edge_max", 64'(cap_code[3]), 5);

    // Random board with ready toggling.
    run_scan({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 1);

    // Flag on a hidden tile and on a revealed tile.
    fl = 64'h60;
    rv = ({$urandom, $urandom} & ~64'h20) | 64'h40;
    mn = {$urandom, $urandom} & ~64'h40;
    run_scan(fl, rv, mn, 0);
    chk("flag_hidden", 64'(cap_code[5]), 10);
    chk("flag_revealed", 64'(cap_code[6]), 64'(model_code(fl, rv, mn, 6)));

    // Inputs scrambled and start re-pulsed mid-scan.
    run_scan({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 2);

    // Reset at tile 30, then a full rescan from index 0.
    run_scan({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 3);
    run_scan({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
